// File: rtl/triangle_setup_pkg.sv
// Shared definitions for the triangle setup block.
// Contents:
//   - CSR bit indices used for the single-bit CSR write-back port
//   - bit offsets of the fields inside a packed 64-bit vertex word
//   - FSM state encoding (exposed on the debug output of the top)
//   - csr_wr(): packs a {bit index, value} pair for one CSR bit write
package triangle_setup_pkg;

  // CSR bit indices
  localparam logic [5:0] CSR_START   = 6'd0;
  localparam logic [5:0] CSR_BUSY    = 6'd1;
  localparam logic [5:0] CSR_DONE    = 6'd2;
  localparam logic [5:0] CSR_DEGEN   = 6'd3;
  localparam logic [5:0] CSR_CULL_EN = 6'd4;
  localparam logic [5:0] CSR_CULLED  = 6'd5;

  // Vertex word field offsets
  localparam int VTX_X_LSB   = 0;
  localparam int VTX_Y_LSB   = 16;
  localparam int VTX_RGB_LSB = 32;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CLR_START = 4'd1,
    ST_SET_BUSY  = 4'd2,
    ST_EDGE0     = 4'd3,
    ST_EDGE1     = 4'd4,
    ST_EDGE2     = 4'd5,
    ST_CLASSIFY  = 4'd6,
    ST_OUT       = 4'd7,
    ST_CLR_BUSY  = 4'd8,
    ST_SET_DONE  = 4'd9
  } state_t;

  function automatic logic [6:0] csr_wr(input logic [5:0] addr, input logic val);
    return {addr, val};
  endfunction

endpackage

// File: rtl/triangle_setup_edge_eval.sv
// Combinational edge-function evaluator for one directed edge V0 -> V1.
// Ports:
//   i_x0, i_y0  start vertex (unsigned pixel coordinates)
//   i_x1, i_y1  end vertex
//   o_a         A = y0 - y1            (two's complement, COORD_W+1 bits)
//   o_b         B = x1 - x0            (two's complement, COORD_W+1 bits)
//   o_c         C = x0*y1 - x1*y0      (two's complement, 2*COORD_W+2 bits)
// All operands are zero-extended before subtraction, so the outputs are
// exact; no truncation occurs at any coordinate value.
module triangle_setup_edge_eval #(
  parameter int COORD_W = 16
) (
  input  logic [COORD_W-1:0]   i_x0,
  input  logic [COORD_W-1:0]   i_y0,
  input  logic [COORD_W-1:0]   i_x1,
  input  logic [COORD_W-1:0]   i_y1,
  output logic [COORD_W:0]     o_a,
  output logic [COORD_W:0]     o_b,
  output logic [2*COORD_W+1:0] o_c
);

  logic [2*COORD_W-1:0] w_p01;
  logic [2*COORD_W-1:0] w_p10;

  assign w_p01 = {{COORD_W{1'b0}}, i_x0} * {{COORD_W{1'b0}}, i_y1};
  assign w_p10 = {{COORD_W{1'b0}}, i_x1} * {{COORD_W{1'b0}}, i_y0};

  assign o_a = {1'b0, i_y0} - {1'b0, i_y1};
  assign o_b = {1'b0, i_x1} - {1'b0, i_x0};
  // Both products are < 2^(2*COORD_W); two guard bits hold the signed difference.
  assign o_c = {2'b00, w_p01} - {2'b00, w_p10};

endmodule

// File: rtl/triangle_setup.sv
// Triangle setup: on software START latches three vertices, computes the
// three edge functions (one shared evaluator, one edge per cycle), the
// signed doubled area and the bounding box, classifies the triangle and
// hands drawable triangles to the rasterizer.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   control_status_in     CSR contents (bit0 START, bit4 CULL_EN)
//   vertex_a/b/c_in       packed vertices: [15:0] x, [31:16] y, [55:32] RGB
//   control_bit_address   CSR bit index of the single-bit write
//   control_bit_load      one-cycle CSR bit write strobe
//   control_bit_in        value written to that CSR bit
//   tri_valid, tri_ready  result handshake to the rasterizer
//   edge_a/edge_b/edge_c  packed A/B/C coefficients, edge 0 in the LSBs
//   area2                 signed 2x area (C0+C1+C2)
//   bbox                  {ymax, xmax, ymin, xmin}
//   tri_colour            flat colour (vertex A RGB)
//   busy                  FSM not in IDLE
//   dbg_state             current FSM state
//
// Handshake: tri_valid rises when the FSM enters OUT. The result outputs
// and tri_valid are held unchanged until a cycle with tri_valid && tri_ready;
// that cycle is the transfer and tri_valid drops on the following edge.
// tri_ready is not looked at in any other state.
module triangle_setup
  import triangle_setup_pkg::*;
#(
  parameter int COORD_W = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [63:0]                 control_status_in,
  input  logic [63:0]                 vertex_a_in,
  input  logic [63:0]                 vertex_b_in,
  input  logic [63:0]                 vertex_c_in,
  output logic [5:0]                  control_bit_address,
  output logic                        control_bit_load,
  output logic                        control_bit_in,
  output logic                        tri_valid,
  input  logic                        tri_ready,
  output logic [3*(COORD_W+1)-1:0]    edge_a,
  output logic [3*(COORD_W+1)-1:0]    edge_b,
  output logic [3*(2*COORD_W+2)-1:0]  edge_c,
  output logic [2*COORD_W+3:0]        area2,
  output logic [4*COORD_W-1:0]        bbox,
  output logic [23:0]                 tri_colour,
  output logic                        busy,
  output logic [3:0]                  dbg_state
);

  localparam int AB_W   = COORD_W + 1;
  localparam int C_W    = 2*COORD_W + 2;
  localparam int AREA_W = 2*COORD_W + 4;

  state_t               r_state;
  logic [COORD_W-1:0]   r_vx [3];
  logic [COORD_W-1:0]   r_vy [3];
  logic [23:0]          r_rgb;
  logic                 r_cull_en;
  logic [AB_W-1:0]      r_ea [3];
  logic [AB_W-1:0]      r_eb [3];
  logic [C_W-1:0]       r_ec [3];
  logic [AREA_W-1:0]    r_area2;
  logic [4*COORD_W-1:0] r_bbox;
  logic                 r_valid;
  logic                 r_bit_load;
  logic [5:0]           r_bit_addr;
  logic                 r_bit_val;

  logic [1:0]           w_i0;
  logic [1:0]           w_i1;
  logic [AB_W-1:0]      w_a;
  logic [AB_W-1:0]      w_b;
  logic [C_W-1:0]       w_c;
  logic [AREA_W-1:0]    w_area;
  logic [COORD_W-1:0]   w_xmin, w_xmax, w_ymin, w_ymax;
  logic                 w_unused;

  // Edge endpoint select: EDGE0 uses V0->V1, EDGE1 V1->V2, EDGE2 V2->V0.
  always_comb begin
    w_i0 = 2'd0;
    w_i1 = 2'd1;
    case (r_state)
      ST_EDGE1: begin w_i0 = 2'd1; w_i1 = 2'd2; end
      ST_EDGE2: begin w_i0 = 2'd2; w_i1 = 2'd0; end
      default:  ;
    endcase
  end

  triangle_setup_edge_eval #(.COORD_W(COORD_W)) u_edge_eval (
    .i_x0 (r_vx[w_i0]),
    .i_y0 (r_vy[w_i0]),
    .i_x1 (r_vx[w_i1]),
    .i_y1 (r_vy[w_i1]),
    .o_a  (w_a),
    .o_b  (w_b),
    .o_c  (w_c)
  );

  // Area is formed in EDGE2 from the two registered C terms plus the live
  // C2, so the classification write can be issued during CLASSIFY itself.
  assign w_area = {{2{r_ec[0][C_W-1]}}, r_ec[0]}
                + {{2{r_ec[1][C_W-1]}}, r_ec[1]}
                + {{2{w_c[C_W-1]}},     w_c};

  always_comb begin
    w_xmin = r_vx[0];
    w_xmax = r_vx[0];
    w_ymin = r_vy[0];
    w_ymax = r_vy[0];
    for (int i = 1; i < 3; i++) begin
      if (r_vx[i] < w_xmin) w_xmin = r_vx[i];
      if (r_vx[i] > w_xmax) w_xmax = r_vx[i];
      if (r_vy[i] < w_ymin) w_ymin = r_vy[i];
      if (r_vy[i] > w_ymax) w_ymax = r_vy[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_rgb      <= '0;
      r_cull_en  <= 1'b0;
      r_area2    <= '0;
      r_bbox     <= '0;
      r_valid    <= 1'b0;
      r_bit_load <= 1'b0;
      r_bit_addr <= '0;
      r_bit_val  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_vx[i] <= '0;
        r_vy[i] <= '0;
        r_ea[i] <= '0;
        r_eb[i] <= '0;
        r_ec[i] <= '0;
      end
    end else begin
      // CSR write strobe is asserted for exactly the cycle of the state that owns it.
      r_bit_load <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (control_status_in[CSR_START]) begin
            r_state                 <= ST_CLR_START;
            r_bit_load              <= 1'b1;
            {r_bit_addr, r_bit_val} <= csr_wr(CSR_START, 1'b0);
          end
        end
        ST_CLR_START: begin
          r_vx[0]   <= vertex_a_in[VTX_X_LSB +: COORD_W];
          r_vy[0]   <= vertex_a_in[VTX_Y_LSB +: COORD_W];
          r_vx[1]   <= vertex_b_in[VTX_X_LSB +: COORD_W];
          r_vy[1]   <= vertex_b_in[VTX_Y_LSB +: COORD_W];
          r_vx[2]   <= vertex_c_in[VTX_X_LSB +: COORD_W];
          r_vy[2]   <= vertex_c_in[VTX_Y_LSB +: COORD_W];
          r_rgb     <= vertex_a_in[VTX_RGB_LSB +: 24];
          r_cull_en <= control_status_in[CSR_CULL_EN];
          r_state                 <= ST_SET_BUSY;
          r_bit_load              <= 1'b1;
          {r_bit_addr, r_bit_val} <= csr_wr(CSR_BUSY, 1'b1);
        end
        ST_SET_BUSY: begin
          r_state                 <= ST_EDGE0;
          r_bit_load              <= 1'b1;
          {r_bit_addr, r_bit_val} <= csr_wr(CSR_DONE, 1'b0);
        end
        ST_EDGE0: begin
          r_ea[0] <= w_a;
          r_eb[0] <= w_b;
          r_ec[0] <= w_c;
          r_state                 <= ST_EDGE1;
          r_bit_load              <= 1'b1;
          {r_bit_addr, r_bit_val} <= csr_wr(CSR_DEGEN, 1'b0);
        end
        ST_EDGE1: begin
          r_ea[1] <= w_a;
          r_eb[1] <= w_b;
          r_ec[1] <= w_c;
          r_state                 <= ST_EDGE2;
          r_bit_load              <= 1'b1;
          {r_bit_addr, r_bit_val} <= csr_wr(CSR_CULLED, 1'b0);
        end
        ST_EDGE2: begin
          r_ea[2]  <= w_a;
          r_eb[2]  <= w_b;
          r_ec[2]  <= w_c;
          r_area2  <= w_area;
          r_bbox   <= {w_ymax, w_xmax, w_ymin, w_xmin};
          r_state  <= ST_CLASSIFY;
          if (w_area == '0) begin
            r_bit_load              <= 1'b1;
            {r_bit_addr, r_bit_val} <= csr_wr(CSR_DEGEN, 1'b1);
          end else if (w_area[AREA_W-1] && r_cull_en) begin
            r_bit_load              <= 1'b1;
            {r_bit_addr, r_bit_val} <= csr_wr(CSR_CULLED, 1'b1);
          end
        end
        ST_CLASSIFY: begin
          if ((r_area2 == '0) || (r_area2[AREA_W-1] && r_cull_en)) begin
            r_state                 <= ST_CLR_BUSY;
            r_bit_load              <= 1'b1;
            {r_bit_addr, r_bit_val} <= csr_wr(CSR_BUSY, 1'b0);
          end else begin
            r_state <= ST_OUT;
            r_valid <= 1'b1;
          end
        end
        ST_OUT: begin
          if (tri_ready) begin
            r_valid                 <= 1'b0;
            r_state                 <= ST_CLR_BUSY;
            r_bit_load              <= 1'b1;
            {r_bit_addr, r_bit_val} <= csr_wr(CSR_BUSY, 1'b0);
          end
        end
        ST_CLR_BUSY: begin
          r_state                 <= ST_SET_DONE;
          r_bit_load              <= 1'b1;
          {r_bit_addr, r_bit_val} <= csr_wr(CSR_DONE, 1'b1);
        end
        ST_SET_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign control_bit_address = r_bit_addr;
  assign control_bit_load    = r_bit_load;
  assign control_bit_in      = r_bit_val;
  assign tri_valid           = r_valid;
  assign edge_a              = {r_ea[2], r_ea[1], r_ea[0]};
  assign edge_b              = {r_eb[2], r_eb[1], r_eb[0]};
  assign edge_c              = {r_ec[2], r_ec[1], r_ec[0]};
  assign area2               = r_area2;
  assign bbox                = r_bbox;
  assign tri_colour          = r_rgb;
  assign busy                = (r_state != ST_IDLE);
  assign dbg_state           = r_state;

  // CSR bits and vertex fields this block never reads.
  assign w_unused = ^{control_status_in[63:5], control_status_in[3:1],
                      vertex_a_in[63:56], vertex_b_in[63:32], vertex_c_in[63:32]};

endmodule
